// File: rtl/seg7_scan_driver.sv
// Four-digit multiplexed 7-segment driver: time-slotted anode scan, per-frame
// input snapshot, per-digit blank/blink/decimal point, registered active-low outputs.
module seg7_scan_driver #(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLINK_FRAMES = 125
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] digits,
  input  logic [3:0]  dp_en,
  input  logic [3:0]  blank,
  input  logic [3:0]  blink_mask,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int            CW      = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);
  localparam logic [7:0]    FRM_MAX = 8'(BLINK_FRAMES - 1);

  logic [CW-1:0] cnt, cnt_nxt;
  logic [1:0]    idx, idx_nxt;
  logic [7:0]    frame_cnt, frame_cnt_nxt;
  logic          phase, phase_nxt;
  logic [15:0]   sh_digits, sh_digits_nxt;
  logic [3:0]    sh_dp, sh_dp_nxt;
  logic [3:0]    sh_blank, sh_blank_nxt;
  logic [3:0]    sh_mask, sh_mask_nxt;
  logic          tick, frame_end;

  logic          dark;
  logic [3:0]    cur_code;
  logic [3:0]    an_nxt;
  logic [6:0]    seg_nxt;
  logic          dp_nxt;

  function automatic logic [6:0] decode(input logic [3:0] code);
    case (code)
      4'h0: decode = 7'b1000000;
      4'h1: decode = 7'b1111001;
      4'h2: decode = 7'b0100100;
      4'h3: decode = 7'b0110000;
      4'h4: decode = 7'b0011001;
      4'h5: decode = 7'b0010010;
      4'h6: decode = 7'b0000010;
      4'h7: decode = 7'b1111000;
      4'h8: decode = 7'b0000000;
      4'h9: decode = 7'b0010000;
      4'hA: decode = 7'b0001000;
      4'hB: decode = 7'b0000011;
      4'hC: decode = 7'b1000110;
      4'hD: decode = 7'b0100001;
      4'hE: decode = 7'b0000110;
      default: decode = 7'b0001110;
    endcase
  endfunction

  always_comb begin
    tick          = (cnt == CNT_MAX);
    frame_end     = tick && (idx == 2'd3);
    cnt_nxt       = tick ? '0 : cnt + 1'b1;
    idx_nxt       = tick ? idx + 2'd1 : idx;
    frame_cnt_nxt = frame_cnt;
    phase_nxt     = phase;
    sh_digits_nxt = sh_digits;
    sh_dp_nxt     = sh_dp;
    sh_blank_nxt  = sh_blank;
    sh_mask_nxt   = sh_mask;
    if (frame_end) begin
      sh_digits_nxt = digits;
      sh_dp_nxt     = dp_en;
      sh_blank_nxt  = blank;
      sh_mask_nxt   = blink_mask;
      if (frame_cnt == FRM_MAX) begin
        frame_cnt_nxt = '0;
        phase_nxt     = ~phase;
      end else begin
        frame_cnt_nxt = frame_cnt + 8'd1;
      end
    end
  end

  // Outputs are built from the post-edge state so they move with idx and a
  // fresh snapshot shows up in the very slot it was captured for.
  always_comb begin
    cur_code = sh_digits_nxt[{idx_nxt, 2'b00} +: 4];
    dark     = !en || sh_blank_nxt[idx_nxt] || (sh_mask_nxt[idx_nxt] && phase_nxt);
    an_nxt   = 4'b1111;
    seg_nxt  = 7'b1111111;
    dp_nxt   = 1'b1;
    if (!dark) begin
      an_nxt  = ~(4'b0001 << idx_nxt);
      seg_nxt = decode(cur_code);
      dp_nxt  = ~sh_dp_nxt[idx_nxt];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      idx       <= 2'd0;
      frame_cnt <= 8'd0;
      phase     <= 1'b0;
      sh_digits <= 16'h0000;
      sh_dp     <= 4'b0000;
      sh_blank  <= 4'b1111;
      sh_mask   <= 4'b0000;
      an        <= 4'b1111;
      seg       <= 7'b1111111;
      dp        <= 1'b1;
    end else begin
      cnt       <= cnt_nxt;
      idx       <= idx_nxt;
      frame_cnt <= frame_cnt_nxt;
      phase     <= phase_nxt;
      sh_digits <= sh_digits_nxt;
      sh_dp     <= sh_dp_nxt;
      sh_blank  <= sh_blank_nxt;
      sh_mask   <= sh_mask_nxt;
      an        <= an_nxt;
      seg       <= seg_nxt;
      dp        <= dp_nxt;
    end
  end

endmodule

// File: doc/seg7_scan_driver.md
SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 Parameter REFRESH_DIV, default 100000, clk cycles per digit slot (1 kHz slot rate at 100 MHz); legal range 2..2^20.
REQ-002 Parameter BLINK_FRAMES, default 125, full scan frames per blink half-period (500 ms at defaults); legal range 1..255.
REQ-003 clk  input  1  system clock; all state on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 en  input  1  display enable; 0 forces all outputs inactive.
REQ-006 digits  input  16  four hex codes, digit i = digits[4i+3:4i], digit 0 rightmost.
REQ-007 dp_en  input  4  decimal point request per digit.
REQ-008 blank  input  4  per-digit blank request.
REQ-009 blink_mask  input  4  per-digit blink select.
REQ-010 an  output  4  anode enables, active-low, registered.
REQ-011 seg  output  7  cathodes {g,f,e,d,c,b,a}, active-low, registered.
REQ-012 dp  output  1  decimal point cathode, active-low, registered.

Function
REQ-013 Slot counter counts 0..REFRESH_DIV-1 and wraps to 0; tick is asserted combinationally while count == REFRESH_DIV-1.
REQ-014 Digit index idx (2 bits) advances on tick, 3 wraps to 0; counters run regardless of en.
REQ-015 Frame snapshot: on a tick with idx==3, digits/dp_en/blank/blink_mask are captured into shadow registers; only shadow values drive outputs (no mid-frame tearing).
REQ-016 Frame counter increments on each tick with idx==3; at BLINK_FRAMES-1 it wraps to 0 and blink_phase toggles in the same cycle.
REQ-017 Digit i is dark when en==0, or shadow blank[i]==1, or (shadow blink_mask[i]==1 and blink_phase==1).
REQ-018 Output register loads every cycle from next-state idx: an = ~(4'b0001<<idx) if digit idx not dark, else 4'b1111; seg = decode(shadow digit idx) if not dark, else 7'b1111111; dp = ~shadow dp_en[idx] if not dark, else 1.
REQ-019 Outputs therefore change in the same edge that idx changes; no extra latency beyond one register stage.
REQ-020 Decode (active-low, {g..a}): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-021 Exactly zero or one an bit is low in every cycle.
REQ-022 en deassertion takes effect at the next clock edge, not at frame boundary; en reassertion resumes at current idx with current shadow values.
REQ-023 Input changes between snapshots have no effect on outputs until the next frame boundary.

Reset
REQ-024 While rst==1: slot counter=0, idx=0, frame counter=0, blink_phase=0, shadow digits=0, shadow dp_en=0, shadow blank=4'b1111, shadow blink_mask=0.
REQ-025 While rst==1: an=4'b1111, seg=7'b1111111, dp=1, asynchronously, including mid-slot or mid-frame.
REQ-026 After rst release display stays dark until the first snapshot (end of first frame, 4*REFRESH_DIV cycles).

Verification (REFRESH_DIV=4, BLINK_FRAMES=2)
REQ-027 digits=16'h1234, en=1, others 0, release reset -> dark for 16 cycles, then an cycles 1110,1101,1011,0111 every 4 cycles with seg 0011001(4),0110000(3),0100100(2),1111001(1).
REQ-028 Change digits to 16'h5678 while idx==1 -> digits 1..3 of current frame still show 3,2,1; new values appear from next idx==0 slot.
REQ-029 blink_mask=4'b0001 -> digit 0 shown for 2 frames, dark (an=1111 in its slot) for 2 frames, repeating; other digits unaffected.
REQ-030 dp_en=4'b0100, blank=4'b1000 -> dp=0 only in idx==2 slot; an stays 1111 and seg 1111111 in idx==3 slot.
REQ-031 en=0 for one slot mid-frame -> next edge an=1111, seg=1111111, dp=1; en=1 -> scanning resumes with idx continuity (no restart).
REQ-032 Assert rst mid-slot at idx==2 -> outputs inactive immediately without clock; release -> idx=0, 16-cycle dark interval repeats.
